// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: bubble encoding, fetch FSM states and
// instruction register-field positions.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that parks a returned instruction
// while the IF/ID register cannot take it.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    output logic        full,
    output logic [31:0] data_instr,
    output logic [31:0] data_pc
);

    logic        full_r;
    logic [31:0] instr_r;
    logic [31:0] pc_r;

    // Entry storage; clear (redirect) outranks push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            instr_r <= 32'd0;
            pc_r    <= 32'd0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (push) begin
            full_r  <= 1'b1;
            instr_r <= push_instr;
            pc_r    <= push_pc;
        end else if (pop) begin
            full_r <= 1'b0;
        end
    end

    assign full       = full_r;
    assign data_instr = instr_r;
    assign data_pc    = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register with a one-outstanding imem handshake.
// Optional FETCH_PERF_CNT_EN adds bubble and discarded-response counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);
    import riscv_pkg::*;

    fetch_state_e state_r;
    logic [31:0]  pcf_r;
    logic [31:0]  req_pc_r;
    logic [31:0]  instr_d_r;
    logic [31:0]  pcd_r;
    logic [31:0]  pcplus4d_r;
    logic         validd_r;

    logic         skid_full_s;
    logic [31:0]  skid_instr_s;
    logic [31:0]  skid_pc_s;
    logic         resp_s;
    logic         req_s;
    logic         fire_s;
    logic         direct_s;
    logic         push_s;
    logic         pop_s;
    logic         drop_s;
    logic         bubble_s;

    // Handshake decode; a new request may overlap only a response heading straight to ID.
    always_comb begin
        resp_s   = (state_r == WAIT) && imem_rvalid;
        req_s    = rst_n && !PCSrcE && !StallF && !skid_full_s &&
                   ((state_r == IDLE) || (resp_s && !StallD && !FlushD));
        fire_s   = req_s && imem_ready;
        direct_s = resp_s && !PCSrcE && !StallD && !FlushD;
        push_s   = resp_s && !PCSrcE && (StallD || FlushD);
        pop_s    = !FlushD && !StallD && skid_full_s;
        drop_s   = imem_rvalid && ((state_r == DISCARD) || ((state_r == WAIT) && PCSrcE));
        bubble_s = !FlushD && !StallD && !skid_full_s && !direct_s;
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .clear      (PCSrcE),
        .push_instr (imem_rdata),
        .push_pc    (req_pc_r),
        .full       (skid_full_s),
        .data_instr (skid_instr_s),
        .data_pc    (skid_pc_s)
    );

    // PC and request FSM; a redirect always wins and kills any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pcf_r    <= RESET_PC;
            req_pc_r <= 32'd0;
        end else begin
            if (fire_s) begin
                req_pc_r <= pcf_r;
            end
            if (PCSrcE) begin
                pcf_r <= PCTargetE;
            end else if (fire_s) begin
                pcf_r <= pc_plus4(pcf_r);
            end
            case (state_r)
                IDLE: begin
                    if (fire_s) state_r <= WAIT;
                end
                WAIT: begin
                    if (PCSrcE) begin
                        if (imem_rvalid) state_r <= IDLE;
                        else             state_r <= DISCARD;
                    end else if (imem_rvalid) begin
                        if (fire_s) state_r <= WAIT;
                        else        state_r <= IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // IF/ID register: flush, stall, skid, direct response, bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d_r  <= NOP_INSTR;
            pcd_r      <= 32'd0;
            pcplus4d_r <= 32'd4;
            validd_r   <= 1'b0;
        end else if (FlushD) begin
            instr_d_r <= NOP_INSTR;
            validd_r  <= 1'b0;
        end else if (StallD) begin
            validd_r <= validd_r;
        end else if (skid_full_s) begin
            instr_d_r  <= skid_instr_s;
            pcd_r      <= skid_pc_s;
            pcplus4d_r <= pc_plus4(skid_pc_s);
            validd_r   <= 1'b1;
        end else if (direct_s) begin
            instr_d_r  <= imem_rdata;
            pcd_r      <= req_pc_r;
            pcplus4d_r <= pc_plus4(req_pc_r);
            validd_r   <= 1'b1;
        end else begin
            instr_d_r <= NOP_INSTR;
            validd_r  <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_r;
    logic [31:0] discard_cnt_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r  <= 32'd0;
            discard_cnt_r <= 32'd0;
        end else begin
            if (bubble_s && (bubble_cnt_r != 32'hFFFF_FFFF)) bubble_cnt_r <= bubble_cnt_r + 32'd1;
            if (drop_s && (discard_cnt_r != 32'hFFFF_FFFF)) discard_cnt_r <= discard_cnt_r + 32'd1;
        end
    end

    assign perf_bubble_cnt  = bubble_cnt_r;
    assign perf_discard_cnt = discard_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s = bubble_s ^ drop_s;
`endif

    assign imem_req  = req_s;
    assign imem_addr = pcf_r;
    assign InstrD    = instr_d_r;
    assign PCD       = pcd_r;
    assign PCPlus4D  = pcplus4d_r;
    assign ValidD    = validd_r;
    assign Rs1D      = instr_d_r[RS1_LSB +: 5];
    assign Rs2D      = instr_d_r[RS2_LSB +: 5];
    assign RdD       = instr_d_r[RD_LSB +: 5];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a small imem responder answers one cycle
// after each accepted request when auto_mem is set.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [4:0]  Rs1D, Rs2D, RdD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt, perf_discard_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    logic auto_mem;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt  (perf_bubble_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    // Instruction at address a: addi x(a/4+1), x0, 5.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0050_0093 + (a << 5);
    endfunction

    // One clock: sample the handshake at negedge, answer just after posedge.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        @(negedge clk);
        hs = imem_req & imem_ready;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = hs;
            imem_rdata  = hs ? memf(a) : 32'd0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'd0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        auto_mem = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (InstrD !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h want 00000013", InstrD); end
        checks++; if (PCD !== 32'd0 || PCPlus4D !== 32'd4) begin errors++; $display("FAIL rst_pc: got %h/%h want 0/4", PCD, PCPlus4D); end
        checks++; if (ValidD !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_valid_req: got %b/%b want 0/0", ValidD, imem_req); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL first_req: got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_idle_start();
        repeat (3) step();
        checks++; if (InstrD !== 32'h0000_0013 || ValidD !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL idle_start: got %h/%b/%h want 00000013/0/0", InstrD, ValidD, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_bubble_cnt !== 32'd3) begin errors++; $display("FAIL perf_bubble: got %0d want 3", perf_bubble_cnt); end
`endif
    endtask

    task automatic test_stream();
        imem_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ValidD !== 1'b0) begin errors++; $display("FAIL stream_issue: got %b/%h/%b want 1/4/0", imem_req, imem_addr, ValidD); end
        step();
        checks++; if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL stream_first: got %h/%h/%h/%b want 00500093/0/4/1", InstrD, PCD, PCPlus4D, ValidD); end
        checks++; if (RdD !== 5'd1 || Rs1D !== 5'd0 || Rs2D !== 5'd5) begin errors++; $display("FAIL stream_fields: got %0d/%0d/%0d want 1/0/5", RdD, Rs1D, Rs2D); end
        step();
        checks++; if (InstrD !== 32'h0050_0113 || PCD !== 32'h4) begin errors++; $display("FAIL stream_second: got %h/%h want 00500113/4", InstrD, PCD); end
        step();
        checks++; if (InstrD !== 32'h0050_0193 || PCD !== 32'h8 || RdD !== 5'd3) begin errors++; $display("FAIL stream_third: got %h/%h/%0d want 00500193/8/3", InstrD, PCD, RdD); end
    endtask

    task automatic test_stall_skid();
        StallD = 1'b1; StallF = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq: got %b want 0", imem_req); end
        step();
        checks++; if (InstrD !== 32'h0050_0193 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold1: got %h/%b want 00500193/0", InstrD, imem_req); end
        step();
        checks++; if (InstrD !== 32'h0050_0193 || ValidD !== 1'b1 || PCD !== 32'h8) begin errors++; $display("FAIL stall_hold2: got %h/%b/%h want 00500193/1/8", InstrD, ValidD, PCD); end
        StallD = 1'b0; StallF = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL skid_full_noreq: got %b want 0", imem_req); end
        step();
        checks++; if (InstrD !== 32'h0050_0213 || PCD !== 32'hC || ValidD !== 1'b1) begin errors++; $display("FAIL skid_drain: got %h/%h/%b want 00500213/c/1", InstrD, PCD, ValidD); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL skid_next_req: got %b/%h want 1/10", imem_req, imem_addr); end
        step();
        checks++; if (ValidD !== 1'b0 || imem_addr !== 32'h14) begin errors++; $display("FAIL skid_bubble: got %b/%h want 0/14", ValidD, imem_addr); end
    endtask

    task automatic test_redirect_discard();
        auto_mem = 1'b0;
        step();
        checks++; if (InstrD !== 32'h0050_0293 || PCD !== 32'h10 || imem_req !== 1'b0) begin errors++; $display("FAIL wait_state: got %h/%h/%b want 00500293/10/0", InstrD, PCD, imem_req); end
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL discard_state: got %b/%h want 0/100", imem_req, imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL discard_noreq: got %b want 0", imem_req); end
        step();
        checks++; if (InstrD !== 32'h0000_0013 || ValidD !== 1'b0) begin errors++; $display("FAIL discard_drop: got %h/%b want 00000013/0", InstrD, ValidD); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redirect_req: got %b/%h want 1/100", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_discard_cnt !== 32'd1) begin errors++; $display("FAIL perf_discard: got %0d want 1", perf_discard_cnt); end
`endif
        auto_mem = 1'b1;
        step();
        step();
        checks++; if (InstrD !== 32'h0050_2093 || PCD !== 32'h100 || ValidD !== 1'b1) begin errors++; $display("FAIL redirect_fetch: got %h/%h/%b want 00502093/100/1", InstrD, PCD, ValidD); end
    endtask

    task automatic test_flush_over_stall();
        FlushD = 1'b1; StallD = 1'b1; imem_ready = 1'b0; auto_mem = 1'b0;
        step();
        checks++; if (InstrD !== 32'h0000_0013 || ValidD !== 1'b0 || PCD !== 32'h100) begin errors++; $display("FAIL flush_wins: got %h/%b/%h want 00000013/0/100", InstrD, ValidD, PCD); end
        FlushD = 1'b0; StallD = 1'b0;
        step();
        checks++; if (InstrD !== 32'h0050_2113 || PCD !== 32'h104 || ValidD !== 1'b1) begin errors++; $display("FAIL flush_skid: got %h/%h/%b want 00502113/104/1", InstrD, PCD, ValidD); end
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b1; StallD = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0 || InstrD !== 32'h0050_2113) begin errors++; $display("FAIL pre_reset: got %b/%h want 0/00502113", imem_req, InstrD); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (InstrD !== 32'h0000_0013 || ValidD !== 1'b0 || PCD !== 32'd0 || PCPlus4D !== 32'd4) begin errors++; $display("FAIL async_rst: got %h/%b/%h/%h want 00000013/0/0/4", InstrD, ValidD, PCD, PCPlus4D); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req: got %b want 0", imem_req); end
        @(posedge clk);
        #2;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; StallD = 1'b0; imem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL post_rst_req: got %b/%h want 1/0", imem_req, imem_addr); end
        step();
        checks++; if (InstrD !== 32'h0000_0013 || ValidD !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL stale_rvalid: got %h/%b/%h want 00000013/0/0", InstrD, ValidD, imem_addr); end
    endtask

    task automatic test_pc_edges();
        PCSrcE = 1'b1; PCTargetE = 32'h202;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redirect_cycle_req: got %b want 0", imem_req); end
        step();
        PCSrcE = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h202 || imem_req !== 1'b1) begin errors++; $display("FAIL misaligned: got %h/%b want 202/1", imem_addr, imem_req); end
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_pc: got %h want fffffffc", imem_addr); end
        imem_ready = 1'b1; auto_mem = 1'b1;
        step();
        checks++; if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin errors++; $display("FAIL pc_wrap: got %h/%b want 0/1", imem_addr, imem_req); end
        step();
        checks++; if (InstrD !== 32'h0050_0013 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'd0) begin errors++; $display("FAIL wrap_idd: got %h/%h/%h want 00500013/fffffffc/0", InstrD, PCD, PCPlus4D); end
        checks++; if (Rs2D !== 5'd5 || RdD !== 5'd0) begin errors++; $display("FAIL wrap_fields: got %0d/%0d want 5/0", Rs2D, RdD); end
    endtask

    initial begin
        test_reset();
        test_idle_start();
        test_stream();
        test_stall_skid();
        test_redirect_discard();
        test_flush_over_stall();
        test_async_reset();
        test_pc_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
